// File: rtl/md_unit.sv
// md_unit: fixed-latency multiply/divide coprocessor owning the HI/LO pair
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic launch, commit, write_ok;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic div_zero, div_ovf;
    logic [WIDTH-1:0] safe_b, q_u, r_u, div_hi, div_lo;
    logic signed [WIDTH-1:0] q_s, r_s;

    // op[0] selects unsigned; sign-extended operands give the signed product in the low 2*WIDTH bits
    assign ext_a = {{WIDTH{~op[0] & src_a[WIDTH-1]}}, src_a};
    assign ext_b = {{WIDTH{~op[0] & src_b[WIDTH-1]}}, src_b};
    assign prod  = ext_a * ext_b;

    // Special cases are resolved by muxing; the divider only ever sees a safe divisor
    assign div_zero = src_b == '0;
    assign div_ovf  = ~op[0] && src_a == {1'b1, {(WIDTH-1){1'b0}}} && src_b == '1;
    assign safe_b   = (div_zero || div_ovf) ? WIDTH'(1) : src_b;
    assign q_s      = $signed(src_a) / $signed(safe_b);
    assign r_s      = $signed(src_a) % $signed(safe_b);
    assign q_u      = src_a / safe_b;
    assign r_u      = src_a % safe_b;
    assign div_lo   = div_zero ? '1 : div_ovf ? src_a : op[0] ? q_u : q_s;
    assign div_hi   = div_zero ? src_a : div_ovf ? '0 : op[0] ? r_u : r_s;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (state == IDLE) next_state = start ? RUN : IDLE;
        else               next_state = (cnt == CNT_W'(1)) ? IDLE : RUN;
    end

    always_comb begin
        launch   = state == IDLE && start;
        commit   = state == RUN && cnt == CNT_W'(1);
        write_ok = state == IDLE && !start;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            res_hi <= '0;
            res_lo <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            busy <= next_state == RUN;
            done <= commit;
            if (launch) begin
                cnt              <= op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                {res_hi, res_lo} <= op[1] ? {div_hi, div_lo} : prod;
            end else if (state == RUN) begin
                cnt <= cnt - CNT_W'(1);
            end
            hi <= commit ? res_hi : (write_ok && hi_we) ? wd : hi;
            lo <= commit ? res_lo : (write_ok && lo_we) ? wd : lo;
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit
module tb_md_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] src_a = '0, src_b = '0, wd = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          n_cmp = 0, n_bad = 0;
    logic [31:0] cur_hi = '0, cur_lo = '0;

    md_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .hi_we(hi_we), .lo_we(lo_we), .wd(wd), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Launch one op; optionally pair it with lo_we, or disturb it mid-run with start+hi_we
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic [31:0] eh, input logic [31:0] el,
                          input bit wr_lo, input bit disturb);
        int cnt = 0;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b; lo_we = wr_lo; wd = 32'hBEEF;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        while (busy && cnt < 30) begin
            cnt++;
            if (cnt == 1) begin
                check({tag, " stale hi"}, hi, cur_hi);
                check({tag, " stale lo"}, lo, cur_lo);
            end
            if (cnt == 2 && disturb) begin
                start = 1'b1; op = 2'd0; src_a = 32'd1; src_b = 32'd1; hi_we = 1'b1; wd = 32'hDEAD;
            end else begin
                start = 1'b0; hi_we = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; hi_we = 1'b0;
        check({tag, " busy cycles"}, 32'(cnt), 32'(n));
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " hi"}, hi, eh);
        check({tag, " lo"}, lo, el);
        cur_hi = eh; cur_lo = el;
        @(negedge clk);
        check({tag, " done drop"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int seen_done = 0;
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        reset = 1'b1;

        hi_we = 1'b1; wd = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi hi", hi, 32'h1234);
        check("mthi lo", lo, 32'd0);
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'h55;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("both hi", hi, 32'h55);
        check("both lo", lo, 32'h55);

        start = 1'b1; op = 2'd0; src_a = 32'd7; src_b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort busy clr", {31'd0, busy}, 32'd0);
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        repeat (12) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        check("abort no done", 32'(seen_done), 32'd0);
        check("abort hi hold", hi, 32'd0);

        run_op("mult", 2'd0, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 1'b0);
        run_op("multu", 2'd1, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA, 1'b0, 1'b0);
        run_op("div", 2'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op("divu0", 2'd3, 32'd100, 32'd0, 10, 32'd100, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("divovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000, 1'b0, 1'b0);
        run_op("start+lo_we", 2'd1, 32'd7, 32'd6, 5, 32'd0, 32'd42, 1'b1, 1'b0);
        run_op("restart", 2'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0, 1'b1);
        run_op("multmin", 2'd0, 32'h80000000, 32'h80000000, 5, 32'h40000000, 32'd0, 1'b0, 1'b0);
        run_op("divneg", 2'd2, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
